// File: rtl/lu_result_buffer.sv
// lu_result_buffer
// ---------------------------------------------------------------------------
// Output stage of the 16-bit logic unit. Each accepted LU result is queued
// together with its destination register tag in a small FIFO. The FIFO feeds
// the register-file writeback port. Valid/ready handshakes on both sides let
// LU issue continue while writeback stalls. An architectural condition-flag
// register keeps the flags of the most recently accepted result.
//
// Parameters
//   DEPTH     FIFO entries (power of two, 2..16)
//   AW        destination register tag width
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears pointers, count, flags)
//   in_valid  / in_ready   upstream handshake; in_ready = (count < DEPTH)
//   in_data   LU result
//   in_eq, in_gt, in_za, in_zb   LU comparison/zero flags
//   in_addr   destination register tag
//   wb_valid  / wb_ready   writeback handshake; head entry offered
//   wb_data, wb_addr       head entry (combinational read)
//   flags     {EQ, GT, ZA, ZB, ZR}; ZR is derived here from in_data
//   count     occupied entries
//
// Build option
//   LU_RB_BYPASS_EN  when defined, an empty buffer forwards the input
//                    combinationally to the writeback port. If wb_ready is
//                    also high, the result is consumed in the same cycle
//                    without being stored.
// ---------------------------------------------------------------------------
module lu_result_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [15:0]                in_data,
   input  logic                       in_eq,
   input  logic                       in_gt,
   input  logic                       in_za,
   input  logic                       in_zb,
   input  logic [AW-1:0]              in_addr,
   output logic                       wb_valid,
   input  logic                       wb_ready,
   output logic [15:0]                wb_data,
   output logic [AW-1:0]              wb_addr,
   output logic [4:0]                 flags,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // Storage is not reset; the count and the pointers decide which entries
   // are meaningful.
   logic [15:0]   data_mem [DEPTH];
   logic [AW-1:0] addr_mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg,  count_next;
   logic [4:0]    flags_reg,  flags_next;

   logic accept;     // upstream handshake completes
   logic push_fifo;  // accepted result is written into storage
   logic pop_fifo;   // a stored head entry retires

   assign in_ready = (count_reg < FULL_COUNT);
   assign accept   = in_valid && in_ready;

`ifdef LU_RB_BYPASS_EN
   logic buf_empty;
   logic bypass;

   assign buf_empty = (count_reg == '0);
   // An empty buffer hands the input straight to writeback. The result is
   // stored only when writeback does not take it in that cycle.
   assign bypass    = buf_empty && in_valid && wb_ready;
   assign push_fifo = accept && !bypass;
   assign pop_fifo  = !buf_empty && wb_ready;
   assign wb_valid  = !buf_empty || in_valid;
   assign wb_data   = buf_empty ? in_data : data_mem[rd_ptr_reg];
   assign wb_addr   = buf_empty ? in_addr : addr_mem[rd_ptr_reg];
`else
   assign push_fifo = accept;
   assign wb_valid  = (count_reg != '0);
   assign pop_fifo  = wb_valid && wb_ready;
   assign wb_data   = data_mem[rd_ptr_reg];
   assign wb_addr   = addr_mem[rd_ptr_reg];
`endif

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      flags_next  = flags_reg;
      if (push_fifo) begin
         wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop_fifo) begin
         rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      case ({push_fifo, pop_fifo})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
      // Flags follow every accepted result, including a bypassed one.
      if (accept) begin
         flags_next = {in_eq, in_gt, in_za, in_zb, (in_data == 16'd0)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         flags_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         flags_reg  <= flags_next;
      end
   end

   // A push in the reset cycle is dropped. The slot is still written, but
   // the pointers reset, so the written data is unreachable.
   always_ff @(posedge clk) begin
      if (push_fifo) begin
         data_mem[wr_ptr_reg] <= in_data;
         addr_mem[wr_ptr_reg] <= in_addr;
      end
   end

   assign flags = flags_reg;
   assign count = count_reg;

endmodule

// File: tb/tb_lu_result_buffer.sv
module tb_lu_result_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_eq, in_gt, in_za, in_zb;
   logic [2:0]  in_addr;
   logic        wb_valid;
   logic        wb_ready;
   logic [15:0] wb_data;
   logic [2:0]  wb_addr;
   logic [4:0]  flags;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q [$];
   logic [15:0] next_val;

   always #5 clk = ~clk;

   lu_result_buffer #(.DEPTH(4), .AW(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_eq    (in_eq),
      .in_gt    (in_gt),
      .in_za    (in_za),
      .in_zb    (in_zb),
      .in_addr  (in_addr),
      .wb_valid (wb_valid),
      .wb_ready (wb_ready),
      .wb_data  (wb_data),
      .wb_addr  (wb_addr),
      .flags    (flags),
      .count    (count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] a,
                        input logic eq, input logic gt, input logic za, input logic zb);
      in_valid = v; in_data = d; in_addr = a;
      in_eq = eq; in_gt = gt; in_za = za; in_zb = zb;
   endtask

   initial begin
      rst = 1'b1; wb_ready = 1'b0;
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b0; #1;
      chk("rst_count",    32'(count),    32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_flags",    32'(flags),    32'h00);

      // Single push, then pop
      drive(1'b1, 16'h00F0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("one_wb_valid", 32'(wb_valid), 32'd1);
      chk("one_wb_data",  32'(wb_data),  32'h00F0);
      chk("one_wb_addr",  32'(wb_addr),  32'd3);
      chk("one_flags",    32'(flags),    32'b01000);
      chk("one_count",    32'(count),    32'd1);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0; #1;
      chk("pop_count",    32'(count),    32'd0);
      chk("pop_wb_valid", 32'(wb_valid), 32'd0);

      // Fill to DEPTH; the last push carries EQ only
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 16'(i), 3'(i), (i == 4), 1'b0, 1'b0, 1'b0);
         tick();
      end
      #1;
      chk("full_count",    32'(count),    32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_flags",    32'(flags),    32'b10000);
      // A 5th offer while full must be ignored
      drive(1'b1, 16'h0005, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("stall_count", 32'(count), 32'd4);
      chk("stall_flags", 32'(flags), 32'b10000);
      wb_ready = 1'b1; #1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", 32'(wb_data), 32'(i));
         chk("drain_addr", 32'(wb_addr), 32'(i));
         tick();
      end
      wb_ready = 1'b0; #1;
      chk("drain_count", 32'(count), 32'd0);

      // Prime two entries, then stream with push and pop together
      next_val = 16'hA000;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, next_val, 3'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(next_val);
         next_val = next_val + 16'h0011;
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, next_val, 3'(k), 1'b0, 1'b0, 1'b0, 1'b0);
         wb_ready = 1'b1; #1;
         chk("ss_count_pre", 32'(count),   32'd2);
         chk("ss_data",      32'(wb_data), 32'(exp_q.pop_front()));
         exp_q.push_back(next_val);
         next_val = next_val + 16'h0011;
         tick();
      end
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("ss_count_post", 32'(count), 32'd2);
      for (int i = 0; i < 2; i++) begin
         chk("ss_tail_data", 32'(wb_data), 32'(exp_q.pop_front()));
         tick();
      end
      wb_ready = 1'b0; #1;
      chk("ss_empty", 32'(count), 32'd0);

      // Zero result sets ZR locally
      drive(1'b1, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("zero_flags", 32'(flags),   32'b10111);
      chk("zero_addr",  32'(wb_addr), 32'd6);

      // Mid-operation reset with count = 3 and a push offered in the reset cycle
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 16'h1234, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      #1;
      chk("mid_count3", 32'(count), 32'd3);
      rst = 1'b1;
      drive(1'b1, 16'h5555, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("mid_count",    32'(count),    32'd0);
      chk("mid_wb_valid", 32'(wb_valid), 32'd0);
      chk("mid_flags",    32'(flags),    32'h00);

`ifdef LU_RB_BYPASS_EN
      drive(1'b1, 16'hABCD, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      wb_ready = 1'b1; #1;
      chk("byp_wb_valid", 32'(wb_valid), 32'd1);
      chk("byp_wb_data",  32'(wb_data),  32'hABCD);
      chk("byp_wb_addr",  32'(wb_addr),  32'd5);
      chk("byp_count",    32'(count),    32'd0);
      tick();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      wb_ready = 1'b0; #1;
      chk("byp_count_after", 32'(count), 32'd0);
      chk("byp_flags",       32'(flags), 32'b10000);
`else
      // An offer into an empty buffer is not visible at writeback until the next cycle
      drive(1'b1, 16'hABCD, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      wb_ready = 1'b0; #1;
      chk("nobyp_wb_valid", 32'(wb_valid), 32'd0);
      tick();
      drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      chk("nobyp_valid1", 32'(wb_valid), 32'd1);
      chk("nobyp_data",   32'(wb_data),  32'hABCD);
      chk("nobyp_count",  32'(count),    32'd1);
      chk("nobyp_flags",  32'(flags),    32'b10000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lu_result_buffer.md
# lu_result_buffer

Downstream stage of the 16-bit logic unit: captures each LU result together with its comparison/zero flags and destination register tag, and queues them in a small FIFO toward the register-file writeback port. Decouples LU issue from writeback stalls with a valid/ready handshake on both sides. Also keeps an architectural condition-flag register that reflects the most recently accepted result.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- AW, 3: width of destination register tag.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  LU result present this cycle.
- in_ready  out  1  buffer can accept; equals (count < DEPTH).
- in_data  in  16  LU result (out_lu).
- in_eq, in_gt, in_za, in_zb  in  1 each  LU flags EQ, GT, ZA, ZB.
- in_addr  in  AW  destination register tag.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  writeback port consumes head.
- wb_data  out  16  head result.
- wb_addr  out  AW  head destination tag.
- flags  out  5  {EQ, GT, ZA, ZB, ZR}, bit 4 down to bit 0.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_data, in_addr} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: wb_valid && wb_ready at a rising edge retires head; rd_ptr increments modulo DEPTH.
- Push and pop in the same cycle: both pointers advance; count unchanged. At count == DEPTH, in_ready = 0 even if wb_ready = 1; there is no full-pass-through.
- count = entries; wb_valid = (count != 0); wb_data/wb_addr are driven from mem[rd_ptr] (combinational read). Their value is don't-care when wb_valid = 0.
- Flags register: on every accepted input (in_valid && in_ready), flags <= {in_eq, in_gt, in_za, in_zb, (in_data == 16'd0)}. Otherwise it holds.
  - ZR is computed locally from the result. It is not taken from the LU.
- in_valid while in_ready = 0: ignored. The input is not stored and flags do not change. The upstream stage holds its values.
- wb_ready while wb_valid = 0: no effect.

## Timing
- Reset (rst = 1 at an edge): wr_ptr = rd_ptr = 0, count = 0, flags = 5'b0, wb_valid = 0, in_ready = 1. Memory contents are not cleared.
- Reset mid-operation discards all queued entries. Any push or pop in the reset cycle is ignored.
- Base latency: an entry pushed at edge N has wb_valid = 1 in the cycle after N. It can be popped at edge N+1 at the earliest.
- Flags update at the same edge as the push and are visible in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering is strictly FIFO across the wrap.

## Configuration
- LU_RB_BYPASS_EN defined:
  - When count == 0, in_valid = 1 and wb_ready = 1, the input passes combinationally to wb_data/wb_addr with wb_valid = 1.
  - The entry is consumed the same cycle and is not written to the FIFO. count stays 0.
  - Flags still update at that edge.
  - wb_valid = (count != 0) || in_valid.
- LU_RB_BYPASS_EN undefined:
  - No combinational path from in_* to wb_*.
  - Minimum latency is one cycle, as in Timing.

## Test plan
- Reset then idle:
  - Stimulus: assert rst for 2 cycles.
  - Required: count = 0, wb_valid = 0, in_ready = 1, flags = 5'b00000.
- Single push/pop:
  - Stimulus: push data 16'h00F0, addr 3, eq = 0, gt = 1, za = 0, zb = 0, with wb_ready = 0.
  - Required next cycle: wb_valid = 1, wb_data = 16'h00F0, wb_addr = 3, flags = 5'b01000, count = 1.
  - Then wb_ready = 1 for one edge. Required: count = 0.
- Fill and stall:
  - Stimulus: push 16'h0001..16'h0004 with wb_ready = 0.
  - Required: count = 4, in_ready = 0.
  - A 5th in_valid with 16'h0005 is ignored and flags are unchanged.
  - Draining yields 1, 2, 3, 4 in order.
- Simultaneous push/pop at count = 2:
  - Required: count stays 2 over 10 cycles.
  - Output order matches input order across pointer wrap, with 12 values total.
- Zero result:
  - Stimulus: push 16'h0000 with eq = 1, za = 1, zb = 1.
  - Required: flags = 5'b10111.
- Mid-operation reset / bypass:
  - Stimulus: assert rst with count = 3.
  - Required next cycle: count = 0, wb_valid = 0.
  - With LU_RB_BYPASS_EN: empty buffer, in_valid = 1, wb_ready = 1, in_data = 16'hABCD. Required same cycle: wb_valid = 1, wb_data = 16'hABCD; count remains 0.
